pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_target_calc.sv | 31 +++
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: next-PC select codes, FSM state encoding, address defaults.
// Latency: none (definitions only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    // Default fetch addresses
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    // Highest legal fetch address when the alignment/range check is built in
    localparam logic [31:0] FETCH_ADDR_MAX = 32'h0000_6FFC;

    // npc_sel codes; 4..7 are reserved and behave like add4
    localparam logic [2:0] NPC_ADD4   = 3'd0;
    localparam logic [2:0] NPC_OFFSET = 3'd1;
    localparam logic [2:0] NPC_INDEX  = 3'd2;
    localparam logic [2:0] NPC_REG    = 3'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC target mux and link address (pc_d + 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; callers decide whether the target is taken.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [2:0]  npc_sel,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] offset,
    input  logic [25:0] index,
    input  logic [31:0] reg_target,
    output logic [31:0] target,
    output logic [31:0] pc_add8
);

    // Select the next sequential/branch/jump target; all sums wrap modulo 2^32
    always_comb begin
        target = pc_f + 32'd4;
        case (npc_sel)
            NPC_ADD4:   target = pc_f + 32'd4;
            NPC_OFFSET: target = pc_d + 32'd4 + offset;
            NPC_INDEX:  target = {pc_d[31:28], index, 2'b00};
            NPC_REG:    target = reg_target;
            default:    target = pc_f + 32'd4;
        endcase
    end

    assign pc_add8 = pc_d + 32'd8;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, run, stall-hold and exception/eret redirect with a one-cycle bubble.
// Latency: new PC one cycle after the request; flush_d and pc_add8 are combinational.
// Backpressure: stall freezes pc_f; req_exc/req_eret override stall. Option macro: PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_sel,
    input  logic [31:0] pc_d,
    input  logic [31:0] offset,
    input  logic [25:0] index,
    input  logic [31:0] reg_target,
    input  logic        req_exc,
    input  logic        req_eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        pc_valid,
    output logic        flush_d,
    output logic [31:0] pc_add8,
    output logic        fetch_adel
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] target;

    pc_target_calc u_target_calc (
        .npc_sel    (npc_sel),
        .pc_f       (pc_f_q),
        .pc_d       (pc_d),
        .offset     (offset),
        .index      (index),
        .reg_target (reg_target),
        .target     (target),
        .pc_add8    (pc_add8)
    );

    // State and PC registers; reset drops any pending redirect or held target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_f_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
        end
    end

    // Next state / next PC; priority exc > eret > redirect bubble > stall > npc_sel
    always_comb begin
        state_d  = state_q;
        pc_f_d   = pc_f_q;
        flush_d  = 1'b0;
        pc_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // Requests are ignored until the first real fetch is issued
                state_d = ST_RUN;
            end
            default: begin
                pc_valid = (state_q != ST_REDIRECT);
                if (req_exc) begin
                    pc_f_d  = HANDLER_PC;
                    flush_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (req_eret) begin
                    pc_f_d  = epc;
                    flush_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (state_q == ST_REDIRECT) begin
                    // Bubble cycle: redirected PC is held, npc_sel has no meaning yet
                    state_d = stall ? ST_HOLD : ST_RUN;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_f_d  = target;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    assign pc_f = pc_f_q;

`ifdef PC_ALIGN_CHECK_EN
    assign fetch_adel = pc_valid &&
                        ((pc_f_q[1:0] != 2'b00) ||
                         (pc_f_q < RESET_PC) ||
                         (pc_f_q > FETCH_ADDR_MAX));
`else
    assign fetch_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_sel;
    logic [31:0] pc_d;
    logic [31:0] offset;
    logic [25:0] index;
    logic [31:0] reg_target;
    logic        req_exc;
    logic        req_eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        pc_valid;
    logic        flush_d;
    logic [31:0] pc_add8;
    logic        fetch_adel;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .pc_d       (pc_d),
        .offset     (offset),
        .index      (index),
        .reg_target (reg_target),
        .req_exc    (req_exc),
        .req_eret   (req_eret),
        .epc        (epc),
        .pc_f       (pc_f),
        .pc_valid   (pc_valid),
        .flush_d    (flush_d),
        .pc_add8    (pc_add8),
        .fetch_adel (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; npc_sel = 3'd0; pc_d = 32'h0; offset = 32'h0;
        index = 26'h0; reg_target = 32'h0; req_exc = 1'b0; req_eret = 1'b0; epc = 32'h0;
        step(); step();
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want 00003000", pc_f); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        checks++; if (fetch_adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b want 0", fetch_adel); end
        req_exc = 1'b1;
        #1;
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_d); end
    endtask

    task automatic test_boot_run();
        // Release reset with a request present: BOOT must ignore it
        reset = 1'b1;
        #1;
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL boot_flush: got %b want 0", flush_d); end
        checks++; if (pc_f !== 32'h3000 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL boot_cycle1: got pc=%h v=%b want 00003000 v=0", pc_f, pc_valid); end
        req_exc = 1'b0;
        step();
        checks++; if (pc_f !== 32'h3000 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL boot_cycle2: got pc=%h v=%b want 00003000 v=1", pc_f, pc_valid); end
        step();
        checks++; if (pc_f !== 32'h3004 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL boot_cycle3: got pc=%h v=%b want 00003004 v=1", pc_f, pc_valid); end
        step();
        checks++; if (pc_f !== 32'h3008 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL boot_cycle4: got pc=%h v=%b want 00003008 v=1", pc_f, pc_valid); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_f !== 32'h3008 || pc_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got pc=%h v=%b want 00003008 v=1", i, pc_f, pc_valid); end
        end
        stall = 1'b0; npc_sel = 3'd3; reg_target = 32'h3100;
        step();
        checks++; if (pc_f !== 32'h3100) begin errors++; $display("FAIL stall_release: got %h want 00003100", pc_f); end
    endtask

    task automatic test_targets();
        pc_d = 32'h3010; npc_sel = 3'd1; offset = 32'h20;
        #1;
        checks++; if (pc_add8 !== 32'h3018) begin errors++; $display("FAIL add8: got %h want 00003018", pc_add8); end
        step();
        checks++; if (pc_f !== 32'h3034) begin errors++; $display("FAIL offset_tgt: got %h want 00003034", pc_f); end
        npc_sel = 3'd2; index = 26'h0000C10;
        step();
        checks++; if (pc_f !== 32'h3040) begin errors++; $display("FAIL index_tgt: got %h want 00003040", pc_f); end
        npc_sel = 3'd5;
        step();
        checks++; if (pc_f !== 32'h3044) begin errors++; $display("FAIL reserved_sel: got %h want 00003044", pc_f); end
        pc_d = 32'hA000_0010; npc_sel = 3'd2; index = 26'h0000004;
        step();
        checks++; if (pc_f !== 32'hA000_0010) begin errors++; $display("FAIL index_hi: got %h want a0000010", pc_f); end
    endtask

    task automatic test_wrap();
        npc_sel = 3'd3; reg_target = 32'hFFFF_FFFC; pc_d = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_add8 !== 32'h0000_0004) begin errors++; $display("FAIL add8_wrap: got %h want 00000004", pc_add8); end
        step();
        checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_set: got %h want fffffffc", pc_f); end
        npc_sel = 3'd0;
        step();
        checks++; if (pc_f !== 32'h0000_0000) begin errors++; $display("FAIL wrap_add4: got %h want 00000000", pc_f); end
    endtask

    task automatic test_exception();
        // Exception and eret together under stall: exception wins and overrides stall
        stall = 1'b1; req_exc = 1'b1; req_eret = 1'b1; epc = 32'h3050;
        npc_sel = 3'd1; pc_d = 32'h3010; offset = 32'h20;
        #1;
        checks++; if (flush_d !== 1'b1) begin errors++; $display("FAIL exc_flush: got %b want 1", flush_d); end
        step();
        checks++; if (pc_f !== 32'h4180 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL exc_redirect: got pc=%h v=%b want 00004180 v=0", pc_f, pc_valid); end
        req_exc = 1'b0; req_eret = 1'b0; stall = 1'b0;
        #1;
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL exc_flush_clear: got %b want 0", flush_d); end
        step();
        checks++; if (pc_f !== 32'h4180 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL exc_run: got pc=%h v=%b want 00004180 v=1", pc_f, pc_valid); end
        npc_sel = 3'd0;
        step();
        checks++; if (pc_f !== 32'h4184) begin errors++; $display("FAIL exc_after: got %h want 00004184", pc_f); end
    endtask

    task automatic test_redirect_restart();
        req_eret = 1'b1; epc = 32'h3050;
        step();
        checks++; if (pc_f !== 32'h3050 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL eret_redirect: got pc=%h v=%b want 00003050 v=0", pc_f, pc_valid); end
        req_eret = 1'b0; req_exc = 1'b1;
        step();
        checks++; if (pc_f !== 32'h4180 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL restart_redirect: got pc=%h v=%b want 00004180 v=0", pc_f, pc_valid); end
        req_exc = 1'b0; stall = 1'b1;
        step();
        checks++; if (pc_f !== 32'h4180 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL redirect_to_hold: got pc=%h v=%b want 00004180 v=1", pc_f, pc_valid); end
        step();
        checks++; if (pc_f !== 32'h4180) begin errors++; $display("FAIL hold_after_redirect: got %h want 00004180", pc_f); end
        stall = 1'b0;
        step();
        checks++; if (pc_f !== 32'h4184) begin errors++; $display("FAIL hold_release: got %h want 00004184", pc_f); end
    endtask

    task automatic test_reset_mid_redirect();
        req_eret = 1'b1; epc = 32'h3050;
        step();
        checks++; if (pc_f !== 32'h3050) begin errors++; $display("FAIL pre_reset_eret: got %h want 00003050", pc_f); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pc_f !== 32'h3000 || pc_valid !== 1'b0 || flush_d !== 1'b0) begin
            errors++; $display("FAIL async_reset: got pc=%h v=%b fl=%b want 00003000 v=0 fl=0", pc_f, pc_valid, flush_d); end
        req_eret = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if (pc_f !== 32'h3000 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL reset_discard: got pc=%h v=%b want 00003000 v=1", pc_f, pc_valid); end
    endtask

    task automatic test_align();
        logic exp_bad;
`ifdef PC_ALIGN_CHECK_EN
        exp_bad = 1'b1;
`else
        exp_bad = 1'b0;
`endif
        npc_sel = 3'd3; reg_target = 32'h3100;
        step();
        checks++; if (fetch_adel !== 1'b0) begin errors++; $display("FAIL adel_aligned: got %b want 0", fetch_adel); end
        reg_target = 32'h3102;
        step();
        checks++; if (pc_f !== 32'h3102) begin errors++; $display("FAIL adel_pc: got %h want 00003102", pc_f); end
        checks++; if (fetch_adel !== exp_bad) begin errors++; $display("FAIL adel_misaligned: got %b want %b", fetch_adel, exp_bad); end
        reg_target = 32'h7000;
        step();
        checks++; if (fetch_adel !== exp_bad) begin errors++; $display("FAIL adel_range: got %b want %b", fetch_adel, exp_bad); end
        npc_sel = 3'd0;
    endtask

    initial begin
        test_reset();
        test_boot_run();
        test_stall();
        test_targets();
        test_wrap();
        test_exception();
        test_redirect_restart();
        test_reset_mid_redirect();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000ns");
        $fatal(1, "timeout");
    end

endmodule
